rank_order_spike_scheduler: RTL

//  Sequences the pixel-intensity sorter and turns its result into a rank-order spike stream.
//  - Accepts an image request on a valid/ready handshake.
//  - Pulses the sorter start, then waits for the sorter done.
//  - Captures the sorted index list into a local buffer.
//  - Streams the first MAX_SPIKES indexes (brightest first) to the SNN core as address events.

---
 rtl/rank_order_spike_scheduler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rank_order_spike_scheduler.sv
// Sequences the pixel sorter and streams its first K sorted indexes as rank-order spikes.
// Optional sorter watchdog under `ifdef SORTER_TIMEOUT_EN (raises sticky sort_err).
//   state     | meaning
//   IDLE      | img_ready high, waiting for an image
//   START     | one-cycle sort_start pulse
//   WAIT_SORT | waiting for sort_done, capturing sorted_in on it
//   STREAM    | emitting buf[cnt] as spikes until rank K-1 is accepted
module rank_order_spike_scheduler #(
  parameter int IMAGE_SIZE     = 5,
  parameter int INDEX_BITS     = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1,
  parameter int MAX_SPIKES     = IMAGE_SIZE,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             img_valid,
  output logic                             img_ready,
  output logic                             sort_start,
  input  logic                             sort_done,
  input  logic [IMAGE_SIZE*INDEX_BITS-1:0] sorted_in,
  output logic                             spike_valid,
  input  logic                             spike_ready,
  output logic [INDEX_BITS-1:0]            spike_addr,
  output logic [INDEX_BITS:0]              spike_rank,
  output logic                             spike_last,
  output logic                             busy,
  output logic                             sort_err
);

  localparam int K = (MAX_SPIKES > IMAGE_SIZE) ? IMAGE_SIZE : MAX_SPIKES;
  localparam logic [INDEX_BITS:0] LAST_RANK = (INDEX_BITS+1)'(K - 1);

  if (MAX_SPIKES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("rank_order_spike_scheduler: MAX_SPIKES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_SORT = 2'd2,
    STREAM    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [INDEX_BITS:0]   cnt_q, cnt_d;
  logic [INDEX_BITS-1:0] buf_q [IMAGE_SIZE];
  logic [INDEX_BITS-1:0] buf_d [IMAGE_SIZE];

`ifdef SORTER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
`ifdef SORTER_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (img_valid) state_d = START;
      end
      START: begin
        state_d = WAIT_SORT;
`ifdef SORTER_TIMEOUT_EN
        tmo_d   = TMO_LOAD;
`endif
      end
      WAIT_SORT: begin
        if (sort_done) begin
          for (int i = 0; i < IMAGE_SIZE; i++) begin
            buf_d[i] = sorted_in[i*INDEX_BITS +: INDEX_BITS];
          end
          cnt_d   = '0;
          state_d = STREAM;
        end
`ifdef SORTER_TIMEOUT_EN
        // Down-counter reaching zero marks the last allowed WAIT_SORT cycle.
        else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
`endif
      end
      STREAM: begin
        if (spike_ready) begin
          if (cnt_q == LAST_RANK) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < IMAGE_SIZE; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

`ifdef SORTER_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign sort_err = err_q;
`else
  assign sort_err = 1'b0;
`endif

  always_comb begin
    spike_addr = '0;
    for (int i = 0; i < IMAGE_SIZE; i++) begin
      if (cnt_q == (INDEX_BITS+1)'(i)) spike_addr = buf_q[i];
    end
  end

  assign img_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign sort_start  = (state_q == START);
  assign spike_valid = (state_q == STREAM);
  assign spike_rank  = cnt_q;
  assign spike_last  = (state_q == STREAM) && (cnt_q == LAST_RANK);

endmodule
